sd_start_arbiter: RTL and testbench
===================================

# sd_start_arbiter

Round-robin start arbiter for the SD read path. It takes level-style start requests from up to N requesters and turns each 0→1 transition into a pending request. It then grants the single shared SD command/read engine to one requester at a time, using a start/done handshake with a timeout. It sits between the control-register/sequencer logic and the engine, and replaces per-requester ad-hoc rising-edge strobes feeding the engine directly.

## Interface
- N_REQ, 4: number of requesters (2..8).
- SEL_W, 2: width of eng_sel; must satisfy 2**SEL_W >= N_REQ.
- TO_W, 16: timeout counter width.
- TIMEOUT, 50000: maximum cycles spent in WAIT before abort (1..2**TO_W-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  gates edge capture and new grants.
- req_lvl  in  N_REQ  per-requester start level; a rising edge requests one transaction.
- eng_done  in  1  one-cycle engine completion strobe.
- eng_start  out  1  one-cycle start strobe to engine.
- eng_sel  out  SEL_W  index of granted requester; stable from eng_start until return to IDLE.
- eng_abort  out  1  one-cycle abort strobe on timeout.
- done_strb  out  N_REQ  one-hot completion strobe to requester.
- timeout_strb  out  N_REQ  one-hot timeout strobe to requester.
- pending  out  N_REQ  requests captured, not yet granted.
- busy  out  1  high whenever state != IDLE.

## Operation
- Edge capture uses two registers per bit: d1 <= req_lvl, d2 <= d1. edge = d1 & ~d2 & {N{enable}}.
- pending[i] is set on edge[i] and cleared on the cycle requester i is granted. If a set and a clear hit the same cycle, set wins, so one new request stays queued.
- An edge on an already-pending bit is merged, not counted.
- FSM states: IDLE, START, WAIT.
- **IDLE:**
  - If enable=1 and pending != 0, select the first set bit scanning upward from (last_grant+1) mod N_REQ, wrapping around.
  - Register the selection into eng_sel and last_grant, clear that pending bit, and go to START.
  - If enable=0, stay in IDLE; pending bits are retained.
- **START:**
  - eng_start=1 for exactly this cycle.
  - Timeout counter cleared to 0.
  - Go to WAIT.
- **WAIT:**
  - The counter increments each cycle.
  - If eng_done=1: done_strb[eng_sel] pulses, then go to IDLE.
  - Else if counter == TIMEOUT-1: timeout_strb[eng_sel] and eng_abort pulse, then go to IDLE.
  - If eng_done and the timeout occur in the same cycle, done wins and no abort is issued.
- eng_done outside WAIT is ignored.
- enable going low during START/WAIT does not abort; the transaction finishes normally.
- Reset values:
  - state=IDLE; d1, d2, pending = 0.
  - last_grant = N_REQ-1, so requester 0 wins first after reset.
  - Counter = 0; eng_sel = 0.
  - All strobes and busy = 0.
- Reset mid-transaction drops the transaction silently: no done, timeout or abort strobe.

## Timing
- All outputs are registered.
- If req_lvl[i] is first sampled high at edge T:
  - pending[i]=1 after T+1.
  - eng_start is high from T+2 to T+3 (IDLE, no competition).
  - busy rises at T+2.
- If eng_done is sampled at edge D:
  - done_strb is high from D to D+1.
  - busy falls at D.
  - The next queued grant's eng_start is high from D+1 to D+2.
- Timeout: eng_abort/timeout_strb rise TIMEOUT+1 cycles after eng_start rises.
- Minimum back-to-back spacing between eng_start pulses is 3 cycles (START, WAIT with immediate done, IDLE).

## Test plan
- Single request: rising edge on req_lvl[2] → pending=0100, then eng_start with eng_sel=2 two cycles after sampling; eng_done 5 cycles later → done_strb=0100 for one cycle, busy low.
- Round-robin: req_lvl=1111 rises together after reset → grants in order 0,1,2,3. Then re-raise 0 and 3 while 1 is granted → the next grants are 2, 3, 0, with wrap-around.
- Timeout: TIMEOUT=10, no eng_done → eng_abort and timeout_strb[sel] pulse exactly 11 cycles after eng_start. Then eng_done at counter==TIMEOUT-1 → done_strb only, no abort.
- Edge/merge rules: hold req_lvl[1] high for 20 cycles → exactly one transaction. A second edge during that same requester's grant cycle stays pending and produces a second transaction.
- Enable gating: enable=0 while req_lvl[0] rises → no pending bit. With pending set and enable=0 → no grant until enable=1. Dropping enable in WAIT still completes with done_strb.
- Reset mid-WAIT: assert reset for 1 cycle → busy, pending and strobes go to 0, no done/abort. The following request on req_lvl[3] is granted normally.

Source files
------------

// File: rtl/sd_start_arbiter.sv
// Round-robin start arbiter: turns rising edges on per-requester start levels into
// pending requests and grants the shared SD engine to one requester at a time.
// Latency: req_lvl edge -> pending 2 clk, -> eng_start 3 clk; done -> next start 1 clk.
// Backpressure: requests queue in pending (merged per requester) while the engine is busy.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   enable          - gates edge capture and new grants (in-flight work completes)
//   req_lvl         - per-requester start level; each rising edge asks for one transaction
//   eng_done        - one-cycle completion strobe from the engine (only honoured in WAIT)
//   eng_start       - one-cycle start strobe to the engine
//   eng_sel         - granted requester index, stable from eng_start until back in IDLE
//   eng_abort       - one-cycle abort strobe when the engine times out
//   done_strb       - one-hot completion strobe back to the granted requester
//   timeout_strb    - one-hot timeout strobe back to the granted requester
//   pending         - captured requests not yet granted
//   busy            - high while a transaction is in flight
module sd_start_arbiter #(
  parameter int N_REQ   = 4,
  parameter int SEL_W   = 2,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req_lvl,
  input  logic             eng_done,
  output logic             eng_start,
  output logic [SEL_W-1:0] eng_sel,
  output logic             eng_abort,
  output logic [N_REQ-1:0] done_strb,
  output logic [N_REQ-1:0] timeout_strb,
  output logic [N_REQ-1:0] pending,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [SEL_W:0]   N_EXT   = (SEL_W + 1)'(N_REQ);
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_REQ - 1);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] req_d1, req_d2, req_edge;
  logic [N_REQ-1:0] grant_clr, pending_nxt, done_nxt, to_nxt;
  logic [SEL_W-1:0] last_grant, last_nxt, sel_nxt, rr_idx;
  logic             rr_found;
  logic [SEL_W:0]   cand;
  logic [TO_W-1:0]  cnt, cnt_nxt;
  logic             start_nxt, abort_nxt;

  assign req_edge = req_d1 & ~req_d2 & {N_REQ{enable}};

  // A grant clears its bit, but a fresh edge in the same cycle re-arms it so
  // the new request is not lost.
  assign pending_nxt = (pending & ~grant_clr) | req_edge;

  // Round-robin pick: first pending bit scanning upward from last_grant+1.
  // cand is one bit wider so the wrap is a single conditional subtract.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant;
    cand     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_grant} + (SEL_W + 1)'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!rr_found && pending[cand[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    start_nxt = 1'b0;
    abort_nxt = 1'b0;
    done_nxt  = '0;
    to_nxt    = '0;
    sel_nxt   = eng_sel;
    last_nxt  = last_grant;
    cnt_nxt   = cnt;
    grant_clr = '0;
    case (state)
      IDLE: begin
        if (enable && rr_found) begin
          state_nxt = START;
          start_nxt = 1'b1;
          sel_nxt   = rr_idx;
          last_nxt  = rr_idx;
          grant_clr = N_REQ'(1) << rr_idx;
        end
      end
      START: begin
        state_nxt = WAIT;
        cnt_nxt   = '0;
      end
      WAIT: begin
        // Done takes priority over a coinciding timeout.
        if (eng_done) begin
          done_nxt  = N_REQ'(1) << eng_sel;
          state_nxt = IDLE;
        end else if (cnt == TO_LAST) begin
          to_nxt    = N_REQ'(1) << eng_sel;
          abort_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_d1       <= '0;
      req_d2       <= '0;
      pending      <= '0;
      last_grant   <= LAST_RST;
      eng_sel      <= '0;
      cnt          <= '0;
      eng_start    <= 1'b0;
      eng_abort    <= 1'b0;
      done_strb    <= '0;
      timeout_strb <= '0;
      busy         <= 1'b0;
    end else begin
      req_d1       <= req_lvl;
      req_d2       <= req_d1;
      pending      <= pending_nxt;
      last_grant   <= last_nxt;
      eng_sel      <= sel_nxt;
      cnt          <= cnt_nxt;
      eng_start    <= start_nxt;
      eng_abort    <= abort_nxt;
      done_strb    <= done_nxt;
      timeout_strb <= to_nxt;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_sd_start_arbiter.sv
// Bench for sd_start_arbiter: directed phases then random traffic, scored against
// a timestamp-based reference model; expected strobes/status queued per clock edge.
// Monitor pops on the falling edge and compares every cycle.
module tb_sd_start_arbiter;

  localparam int N   = 4;
  localparam int TMO = 10;

  logic       clk = 1'b0;
  logic       reset, enable, eng_done;
  logic [3:0] req_lvl;
  logic       eng_start, eng_abort, busy;
  logic [1:0] eng_sel;
  logic [3:0] done_strb, timeout_strb, pending;

  sd_start_arbiter #(.N_REQ(N), .SEL_W(2), .TO_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_lvl(req_lvl), .eng_done(eng_done),
    .eng_start(eng_start), .eng_sel(eng_sel), .eng_abort(eng_abort),
    .done_strb(done_strb), .timeout_strb(timeout_strb), .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [11:0] w;   // {start, sel, done[3:0], to[3:0], abort}
  } ev_t;

  ev_t        evq[$];
  logic [6:0] stq[$];  // {pending, busy, sel-if-busy}

  int         cyc = 0;
  logic [3:0] h1 = '0, h2 = '0, pend = '0, rise;
  int         last = N - 1;
  bit         active = 0, was_active;
  int         t_start = 0;
  int         sel = 0;
  int         gi;
  bit         gfound;

  function automatic logic [11:0] mkw(bit st, int s, logic [3:0] d, logic [3:0] t, bit a);
    logic [1:0] s2;
    s2 = 2'(s);
    return {st, s2, d, t, a};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        h1 = '0; h2 = '0; pend = '0; last = N - 1; active = 0; sel = 0;
      end else begin
        rise = h1 & ~h2 & {4{enable}};
        was_active = active;
        // Transaction ends: engine window starts two edges after the start edge.
        if (active && cyc >= t_start + 2) begin
          if (eng_done) begin
            evq.push_back('{cyc: cyc, w: mkw(0, 0, 4'b0001 << sel, 4'b0, 0)});
            active = 0;
          end else if (cyc == t_start + 1 + TMO) begin
            evq.push_back('{cyc: cyc, w: mkw(0, 0, 4'b0, 4'b0001 << sel, 1)});
            active = 0;
          end
        end
        if (!was_active && enable && pend != 0) begin
          gfound = 0;
          gi = 0;
          for (int k = 1; k <= N; k++) begin
            if (!gfound && pend[(last + k) % N]) begin
              gfound = 1;
              gi = (last + k) % N;
            end
          end
          pend[gi] = 1'b0;
          last = gi; sel = gi; active = 1; t_start = cyc;
          evq.push_back('{cyc: cyc, w: mkw(1, gi, 4'b0, 4'b0, 0)});
        end
        pend = pend | rise;
        h2 = h1;
        h1 = req_lvl;
      end
      stq.push_back({pend, active, active ? 2'(sel) : 2'b00});
    end
  end

  // ---------------- monitor ----------------
  logic [11:0] exp_w, act_w;
  logic [6:0]  exp_st;

  initial begin
    forever begin
      @(negedge clk);
      if (stq.size() > 0) begin
        exp_st = stq.pop_front();
        check("status", 12'({pending, busy, busy ? eng_sel : 2'b00}), 12'(exp_st));
        exp_w = '0;
        if (evq.size() > 0 && evq[0].cyc == cyc) exp_w = evq.pop_front().w;
        act_w = {eng_start, eng_start ? eng_sel : 2'b00, done_strb, timeout_strb, eng_abort};
        check("strobes", act_w, exp_w);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic rpt(input int n, input bit r, input bit en, input logic [3:0] lvl, input bit dn);
    for (int i = 0; i < n; i++) begin
      reset = r; enable = en; req_lvl = lvl; eng_done = dn;
      @(posedge clk);
      #2;
    end
  endtask

  logic [3:0] lvl_r;

  initial begin
    reset = 1'b1; enable = 1'b1; req_lvl = '0; eng_done = 1'b0;
    rpt(3, 1, 1, 4'b0000, 0);

    // single request on requester 2, engine completes 5 cycles after start
    rpt(7, 0, 1, 4'b0100, 0);
    rpt(1, 0, 1, 4'b0100, 1);
    rpt(4, 0, 1, 4'b0000, 0);

    // all four rise together; 0 and 3 re-raised while 1 is in flight
    rpt(5, 0, 1, 4'b1111, 1);
    rpt(2, 0, 1, 4'b0110, 1);
    rpt(20, 0, 1, 4'b1111, 1);

    // timeout with no done, then done exactly on the timeout cycle
    rpt(3, 0, 1, 4'b0000, 0);
    rpt(20, 0, 1, 4'b0001, 0);
    rpt(2, 0, 1, 4'b0000, 0);
    rpt(13, 0, 1, 4'b0010, 0);
    rpt(1, 0, 1, 4'b0010, 1);
    rpt(3, 0, 1, 4'b0000, 0);

    // held level gives one transaction
    rpt(20, 0, 1, 4'b0010, 1);
    rpt(3, 0, 1, 4'b0000, 0);

    // enable gating: edge ignored, pending held without grant, enable drop in WAIT
    rpt(5, 0, 0, 4'b0001, 0);
    rpt(3, 0, 0, 4'b0000, 0);
    rpt(2, 0, 1, 4'b0001, 0);
    rpt(5, 0, 0, 4'b0001, 0);
    rpt(4, 0, 1, 4'b0001, 0);
    rpt(3, 0, 0, 4'b0001, 0);
    rpt(1, 0, 0, 4'b0001, 1);
    rpt(3, 0, 1, 4'b0000, 0);

    // reset mid-WAIT, then a normal request on requester 3
    rpt(6, 0, 1, 4'b1000, 0);
    rpt(1, 1, 1, 4'b1000, 0);
    rpt(2, 0, 1, 4'b0000, 0);
    rpt(6, 0, 1, 4'b1000, 0);
    rpt(1, 0, 1, 4'b1000, 1);
    rpt(3, 0, 1, 4'b0000, 0);

    // random traffic
    lvl_r = '0;
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) lvl_r[b] = ~lvl_r[b];
      rpt(1, ($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0), lvl_r,
          ($urandom_range(0, 5) == 0));
    end

    // drain
    rpt(30, 0, 1, 4'b0000, 1);
    @(negedge clk);
    #1;
    check("evq_drained", 12'(evq.size()), 12'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
